// File: rtl/stream_detect_ctrl.sv
// Byte-stream controller feeding a bit-serial PAT_W-bit pattern matcher (MSB first) with per-frame match accounting and a sticky threshold irq.
// Define STREAM_DETECT_CTRL_OVERLAP_EN for overlapping detection; the default build restarts matching after each hit.
module stream_detect_ctrl #(
   parameter int DATA_W = 8,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_cfg_we,
   input  logic [PAT_W-1:0]  i_cfg_pattern,
   input  logic [CNT_W-1:0]  i_cfg_threshold,
   input  logic              i_start,
   input  logic              i_s_valid,
   input  logic [DATA_W-1:0] i_s_data,
   input  logic              i_s_last,
   output logic              o_s_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_match_pulse,
   output logic [CNT_W-1:0]  o_match_count,
   output logic              o_irq,
   input  logic              i_irq_clr
);

   localparam int BI_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int VC_W = $clog2(PAT_W + 1);
   localparam logic [BI_W-1:0] BI_MSB  = BI_W'(DATA_W - 1);
   localparam logic [VC_W-1:0] VC_FULL = VC_W'(PAT_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [PAT_W-1:0]  r_pattern;
   logic [CNT_W-1:0]  r_threshold;
   logic [PAT_W-1:0]  r_hist;
   logic [VC_W-1:0]   r_vcnt;
   logic [BI_W-1:0]   r_bit_idx;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [CNT_W-1:0]  r_match_count;
   logic              r_irq;
   logic              r_done;
   logic              r_match_pulse;
   logic              r_busy;
   logic              r_s_ready;

   logic              w_bit;
   logic [PAT_W-1:0]  w_hist_next;
   logic [VC_W-1:0]   w_vcnt_next;
   logic [VC_W-1:0]   w_vcnt_upd;
   logic              w_match;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic              w_irq_set;

   assign w_bit       = r_data[r_bit_idx];
   assign w_hist_next = {r_hist[PAT_W-2:0], w_bit};
   assign w_vcnt_next = (r_vcnt == VC_FULL) ? VC_FULL : r_vcnt + 1'b1;
   assign w_match     = (w_vcnt_next == VC_FULL) && (w_hist_next == r_pattern);
   assign w_cnt_inc   = (&r_match_count) ? r_match_count : r_match_count + 1'b1;
   assign w_irq_set   = w_match && (r_threshold != '0) && (w_cnt_inc == r_threshold);

`ifdef STREAM_DETECT_CTRL_OVERLAP_EN
   assign w_vcnt_upd = w_vcnt_next;
`else
   // A hit consumes its bits: PAT_W fresh bits are needed before the next compare.
   assign w_vcnt_upd = w_match ? '0 : w_vcnt_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pattern     <= '0;
         r_threshold   <= '0;
         r_hist        <= '0;
         r_vcnt        <= '0;
         r_bit_idx     <= '0;
         r_data        <= '0;
         r_last        <= 1'b0;
         r_match_count <= '0;
         r_irq         <= 1'b0;
         r_done        <= 1'b0;
         r_match_pulse <= 1'b0;
         r_busy        <= 1'b0;
         r_s_ready     <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_match_pulse <= 1'b0;
         // Clear first so a same-cycle set below takes priority.
         if (i_irq_clr) begin
            r_irq <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (i_cfg_we) begin
                  r_pattern   <= i_cfg_pattern;
                  r_threshold <= i_cfg_threshold;
               end
               if (i_start) begin
                  r_state       <= S_RUN;
                  r_s_ready     <= 1'b1;
                  r_busy        <= 1'b1;
                  r_match_count <= '0;
                  r_hist        <= '0;
                  r_vcnt        <= '0;
               end
            end
            S_RUN: begin
               if (i_s_valid) begin
                  r_data    <= i_s_data;
                  r_last    <= i_s_last;
                  r_bit_idx <= BI_MSB;
                  r_state   <= S_SHIFT;
                  r_s_ready <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_hist <= w_hist_next;
               r_vcnt <= w_vcnt_upd;
               if (w_match) begin
                  r_match_pulse <= 1'b1;
                  r_match_count <= w_cnt_inc;
                  if (w_irq_set) begin
                     r_irq <= 1'b1;
                  end
               end
               if (r_bit_idx == '0) begin
                  if (r_last) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_RUN;
                     r_s_ready <= 1'b1;
                  end
               end else begin
                  r_bit_idx <= r_bit_idx - 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_s_ready     = r_s_ready;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_match_pulse = r_match_pulse;
   assign o_match_count = r_match_count;
   assign o_irq         = r_irq;

endmodule

// File: tb/tb_stream_detect_ctrl.sv
// Directed bench for stream_detect_ctrl: framing, matcher timing, irq priority, back-to-back bytes, mid-frame reset.
module tb_stream_detect_ctrl;

   localparam int DATA_W = 8;
   localparam int PAT_W  = 4;
   localparam int CNT_W  = 16;
`ifdef STREAM_DETECT_CTRL_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_cfg_we = 1'b0;
   logic [PAT_W-1:0]  i_cfg_pattern = '0;
   logic [CNT_W-1:0]  i_cfg_threshold = '0;
   logic              i_start = 1'b0;
   logic              i_s_valid = 1'b0;
   logic [DATA_W-1:0] i_s_data = '0;
   logic              i_s_last = 1'b0;
   logic              i_irq_clr = 1'b0;
   logic              o_s_ready;
   logic              o_busy;
   logic              o_done;
   logic              o_match_pulse;
   logic [CNT_W-1:0]  o_match_count;
   logic              o_irq;

   stream_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_cfg_we        (i_cfg_we),
      .i_cfg_pattern   (i_cfg_pattern),
      .i_cfg_threshold (i_cfg_threshold),
      .i_start         (i_start),
      .i_s_valid       (i_s_valid),
      .i_s_data        (i_s_data),
      .i_s_last        (i_s_last),
      .o_s_ready       (o_s_ready),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_match_pulse   (o_match_pulse),
      .o_match_count   (o_match_count),
      .o_irq           (o_irq),
      .i_irq_clr       (i_irq_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_pulse, n_done, n_ready, done_cyc, irq_rise_cyc, frame_start;
   int pulse_cyc[$];
   int hs_cyc[$];
   logic prev_irq;
   logic snap_ready, snap_busy, snap_done, snap_pulse, snap_irq;
   logic [CNT_W-1:0] snap_count, pre_count;

   // Advance to the next falling edge and record what the DUT shows in that cycle.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (o_match_pulse) begin
         n_pulse++;
         pulse_cyc.push_back(cyc);
      end
      if (o_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (o_s_ready) n_ready++;
      if (o_irq && !prev_irq) irq_rise_cyc = cyc;
      prev_irq = o_irq;
   endtask

   task automatic clear_stats();
      n_pulse = 0; n_done = 0; n_ready = 0;
      done_cyc = -1; irq_rise_cyc = -1;
      pulse_cyc.delete();
      hs_cyc.delete();
      prev_irq = o_irq;
   endtask

   task automatic configure(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] thr);
      i_cfg_we = 1'b1; i_cfg_pattern = pat; i_cfg_threshold = thr;
      step();
      i_cfg_we = 1'b0;
   endtask

   // Frame of n bytes with s_valid held; k counts cycles from the start pulse.
   task automatic run_frame(input logic [23:0] bytes, input int n, input int clr_at,
                            input int poke_at, input int rst_at);
      int idx;
      bit hs;
      bit fin;
      clear_stats();
      frame_start = cyc;
      idx = 0; hs = 1'b0; fin = 1'b0;
      i_start = 1'b1; i_s_valid = 1'b1; i_s_data = bytes[23:16]; i_s_last = (n == 1);
      for (int k = 0; k < 300 && !fin; k++) begin
         if (k > 0) begin
            i_start  = (k == poke_at);
            i_cfg_we = (k == poke_at);
         end
         if (k == poke_at) begin
            i_cfg_pattern = 4'b0000; i_cfg_threshold = 16'd1;
         end
         i_irq_clr = (k == clr_at);
         if (k == rst_at) begin
            pre_count = o_match_count;
            rst_n = 1'b0;
            #1;
            snap_ready = o_s_ready; snap_busy = o_busy; snap_done = o_done;
            snap_pulse = o_match_pulse; snap_irq = o_irq; snap_count = o_match_count;
            fin = 1'b1;
         end else begin
            if (o_s_ready && i_s_valid) begin
               hs_cyc.push_back(cyc);
               hs = 1'b1;
            end
            step();
            if (hs) begin
               hs = 1'b0;
               idx++;
               if (idx < n) begin
                  i_s_data = bytes[23-8*idx -: 8];
                  i_s_last = (idx == n - 1);
               end else begin
                  i_s_valid = 1'b0; i_s_last = 1'b0;
               end
            end
            if (n_done > 0) fin = 1'b1;
         end
      end
      i_start = 1'b0; i_cfg_we = 1'b0; i_irq_clr = 1'b0;
      i_s_valid = 1'b0; i_s_last = 1'b0; i_s_data = '0;
      if (rst_at < 0) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_s_valid = 1'b1; i_start = 1'b1;
      step(); step();
      n_cmp++; if (o_s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", o_s_ready); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", o_done); end
      n_cmp++; if (o_match_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_pulse: got %b want 0", o_match_pulse); end
      n_cmp++; if (o_match_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", o_match_count); end
      n_cmp++; if (o_irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", o_irq); end
      i_start = 1'b0;
      rst_n = 1'b1;
      clear_stats();
      repeat (5) step();
      n_cmp++; if (n_ready !== 0) begin n_bad++; $display("FAIL rst_ready_idle: got %0d ready cycles want 0", n_ready); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_idle: got %b want 0", o_busy); end
      i_s_valid = 1'b0;
      step();
   endtask

   task automatic test_single_byte();
      int p_first, p_last;
      configure(4'b1011, 16'd0);
      run_frame({8'hB6, 16'h0}, 1, -1, -1, -1);
      p_first = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1;
      p_last  = (pulse_cyc.size() > 0) ? pulse_cyc[pulse_cyc.size()-1] : -1;
      n_cmp++; if (n_pulse !== (OVL ? 2 : 1)) begin n_bad++; $display("FAIL b6_pulses: got %0d want %0d", n_pulse, OVL ? 2 : 1); end
      n_cmp++; if (p_first !== frame_start + 6) begin n_bad++; $display("FAIL b6_first_pulse_cyc: got %0d want %0d", p_first, frame_start + 6); end
      n_cmp++; if (p_last !== frame_start + (OVL ? 9 : 6)) begin n_bad++; $display("FAIL b6_last_pulse_cyc: got %0d want %0d", p_last, frame_start + (OVL ? 9 : 6)); end
      n_cmp++; if (o_match_count !== (OVL ? 16'd2 : 16'd1)) begin n_bad++; $display("FAIL b6_count: got %0d want %0d", o_match_count, OVL ? 2 : 1); end
      n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL b6_done_count: got %0d want 1", n_done); end
      n_cmp++; if (done_cyc !== frame_start + 10) begin n_bad++; $display("FAIL b6_done_cyc: got %0d want %0d", done_cyc, frame_start + 10); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL b6_busy_after: got %b want 0", o_busy); end
      n_cmp++; if (o_irq !== 1'b0) begin n_bad++; $display("FAIL b6_irq_thr0: got %b want 0", o_irq); end
   endtask

   task automatic test_cross_byte();
      int p_first;
      run_frame({8'h01, 8'h60, 8'h00}, 2, -1, -1, -1);
      p_first = (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1;
      n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL cross_pulses: got %0d want 1", n_pulse); end
      n_cmp++; if (p_first !== frame_start + 14) begin n_bad++; $display("FAIL cross_pulse_cyc: got %0d want %0d", p_first, frame_start + 14); end
      n_cmp++; if (o_match_count !== 16'd1) begin n_bad++; $display("FAIL cross_count: got %0d want 1", o_match_count); end
      n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL cross_done: got %0d want 1", n_done); end
   endtask

   task automatic test_irq();
      logic [23:0] bytes;
      int nb;
      bytes = OVL ? {8'hB6, 16'h0} : {8'hB6, 8'hB6, 8'h00};
      nb    = OVL ? 1 : 2;
      configure(4'b1011, 16'd2);
      run_frame(bytes, nb, -1, -1, -1);
      n_cmp++; if (n_pulse !== 2) begin n_bad++; $display("FAIL irq_pulses: got %0d want 2", n_pulse); end
      n_cmp++; if (irq_rise_cyc !== frame_start + (OVL ? 9 : 15)) begin n_bad++; $display("FAIL irq_rise_cyc: got %0d want %0d", irq_rise_cyc, frame_start + (OVL ? 9 : 15)); end
      n_cmp++; if (o_irq !== 1'b1) begin n_bad++; $display("FAIL irq_sticky: got %b want 1", o_irq); end
      run_frame(bytes, nb, OVL ? 8 : 14, -1, -1);
      n_cmp++; if (o_irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_beats_clr: got %b want 1", o_irq); end
      n_cmp++; if (o_match_count !== 16'd2) begin n_bad++; $display("FAIL irq_count: got %0d want 2", o_match_count); end
      i_irq_clr = 1'b1;
      step();
      i_irq_clr = 1'b0;
      n_cmp++; if (o_irq !== 1'b0) begin n_bad++; $display("FAIL irq_clr: got %b want 0", o_irq); end
      configure(4'b1011, 16'd0);
   endtask

   task automatic test_back_to_back();
      int gap0, gap1;
      run_frame({8'h00, 8'h00, 8'h00}, 3, -1, 12, -1);
      gap0 = (hs_cyc.size() == 3) ? hs_cyc[1] - hs_cyc[0] : -1;
      gap1 = (hs_cyc.size() == 3) ? hs_cyc[2] - hs_cyc[1] : -1;
      n_cmp++; if (n_ready !== 3) begin n_bad++; $display("FAIL b2b_ready_cycles: got %0d want 3", n_ready); end
      n_cmp++; if (gap0 !== 9) begin n_bad++; $display("FAIL b2b_gap0: got %0d want 9", gap0); end
      n_cmp++; if (gap1 !== 9) begin n_bad++; $display("FAIL b2b_gap1: got %0d want 9", gap1); end
      n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 0", n_pulse); end
      n_cmp++; if (done_cyc !== frame_start + 28) begin n_bad++; $display("FAIL b2b_done_cyc: got %0d want %0d", done_cyc, frame_start + 28); end
      n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL b2b_done: got %0d want 1", n_done); end
      run_frame({8'hB6, 16'h0}, 1, -1, -1, -1);
      n_cmp++; if (n_pulse !== (OVL ? 2 : 1)) begin n_bad++; $display("FAIL b2b_pattern_kept: got %0d pulses want %0d", n_pulse, OVL ? 2 : 1); end
      n_cmp++; if (o_irq !== 1'b0) begin n_bad++; $display("FAIL b2b_threshold_kept: got irq %b want 0", o_irq); end
   endtask

   task automatic test_reset_midframe();
      run_frame({8'hB0, 8'hA0, 8'h00}, 2, -1, -1, 14);
      n_cmp++; if (pre_count !== 16'd1) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 1", pre_count); end
      n_cmp++; if (snap_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", snap_busy); end
      n_cmp++; if (snap_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", snap_count); end
      n_cmp++; if ({snap_ready, snap_done, snap_pulse, snap_irq} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 0000", {snap_ready, snap_done, snap_pulse, snap_irq}); end
      step(); step();
      rst_n = 1'b1;
      step();
      configure(4'b1011, 16'd0);
      run_frame({8'h80, 16'h0}, 1, -1, -1, -1);
      n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL mid_no_stale_history: got %0d pulses want 0", n_pulse); end
      n_cmp++; if (o_match_count !== 16'd0) begin n_bad++; $display("FAIL mid_new_count: got %0d want 0", o_match_count); end
      n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL mid_new_done: got %0d want 1", n_done); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_cross_byte();
      test_irq();
      test_back_to_back();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
